// File: rtl/gate_identifier.sv
// Gate characterizer: sweeps {a,b} over 00..11 for PASSES passes, captures the
// response of one gate instance and decodes the truth table into a gate code.
module gate_identifier #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_y,
    output logic       stim_a,
    output logic       stim_b,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_table,
    output logic [2:0] gate_code,
    output logic       unstable
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DECODE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] PASS_LAST   = 2'(PASSES - 1);

    state_t     state_q, state_d;
    logic [3:0] settle_q;
    logic [1:0] vec_q;
    logic [1:0] pass_q;
    logic [3:0] cap_q;
    logic       mism_q;

    function automatic logic [2:0] decode_gate(input logic [3:0] tt, input logic mism);
        logic [2:0] code;
        case (tt)
            4'h8:    code = 3'd0;
            4'hE:    code = 3'd1;
            4'h7:    code = 3'd2;
            4'h1:    code = 3'd3;
            4'h6:    code = 3'd4;
            4'h9:    code = 3'd5;
            4'h3:    code = 3'd6;
            default: code = 3'd7;
        endcase
        // An unstable gate cannot be trusted to be any library type.
        if (mism) code = 3'd7;
        return code;
    endfunction

    // The vector index register is the stimulus; it only moves at vector boundaries.
    assign {stim_a, stim_b} = vec_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = DRIVE;
            DRIVE:  if (settle_q == SETTLE_LAST) state_d = SAMPLE;
            SAMPLE: begin
                if (vec_q == 2'd3 && pass_q == PASS_LAST) state_d = DECODE;
                else                                      state_d = DRIVE;
            end
            DECODE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q    <= 4'd0;
            vec_q       <= 2'd0;
            pass_q      <= 2'd0;
            cap_q       <= 4'd0;
            mism_q      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= 4'h0;
            gate_code   <= 3'd7;
            unstable    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        settle_q <= 4'd0;
                        vec_q    <= 2'd0;
                        pass_q   <= 2'd0;
                        cap_q    <= 4'd0;
                        mism_q   <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                DRIVE: begin
                    settle_q <= settle_q + 4'd1;
                end
                SAMPLE: begin
                    settle_q <= 4'd0;
                    if (pass_q == 2'd0) cap_q[vec_q] <= dut_y;
                    else if (dut_y != cap_q[vec_q]) mism_q <= 1'b1;
                    if (vec_q != 2'd3) begin
                        vec_q <= vec_q + 2'd1;
                    end else if (pass_q != PASS_LAST) begin
                        pass_q <= pass_q + 2'd1;
                        vec_q  <= 2'd0;
                    end
                end
                DECODE: begin
                    truth_table <= cap_q;
                    unstable    <= mism_q;
                    gate_code   <= decode_gate(cap_q, mism_q);
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    vec_q       <= 2'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_identifier.sv
// Directed bench for gate_identifier: gate models on dut_y, latency, stability,
// back-to-back starts and mid-run reset.
module tb_gate_identifier;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       dut_y;
    logic       stim_a, stim_b, busy, done, unstable;
    logic [3:0] truth_table;
    logic [2:0] gate_code;

    logic       start_f;
    logic       stim_a_f, stim_b_f, busy_f, done_f, unstable_f;
    logic [3:0] truth_table_f;
    logic [2:0] gate_code_f;

    logic [3:0] model;
    logic       flip;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign dut_y = model[{stim_a, stim_b}] ^ (flip & stim_a & stim_b);

    gate_identifier u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_y(dut_y),
        .stim_a(stim_a), .stim_b(stim_b), .busy(busy), .done(done),
        .truth_table(truth_table), .gate_code(gate_code), .unstable(unstable)
    );

    gate_identifier #(.SETTLE_CYCLES(1), .PASSES(1)) u_fast (
        .clk(clk), .rst_n(rst_n), .start(start_f), .dut_y(1'b0),
        .stim_a(stim_a_f), .stim_b(stim_b_f), .busy(busy_f), .done(done_f),
        .truth_table(truth_table_f), .gate_code(gate_code_f), .unstable(unstable_f)
    );

    typedef struct {
        string      name;
        logic [3:0] model;
        logic [3:0] exp_tt;
        logic [2:0] exp_code;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start across one rising edge (E0); returns at the negedge after E0.
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Counts negedges until done is seen; gives 999 if the bound expires.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = 999;
    endtask

    initial begin
        int lat, stim_errs, done_cnt, first_idx, second_idx;
        logic busy_after;

        vecs[0] = '{"and",  4'h8, 4'h8, 3'd0};
        vecs[1] = '{"or",   4'hE, 4'hE, 3'd1};
        vecs[2] = '{"nand", 4'h7, 4'h7, 3'd2};
        vecs[3] = '{"nor",  4'h1, 4'h1, 3'd3};
        vecs[4] = '{"xor",  4'h6, 4'h6, 3'd4};
        vecs[5] = '{"xnor", 4'h9, 4'h9, 3'd5};
        vecs[6] = '{"not",  4'h3, 4'h3, 3'd6};
        vecs[7] = '{"zero", 4'h0, 4'h0, 3'd7};
        vecs[8] = '{"one",  4'hF, 4'hF, 3'd7};
        vecs[9] = '{"buf",  4'hC, 4'hC, 3'd7};

        rst_n = 1'b0; start = 1'b0; start_f = 1'b0; model = 4'h8; flip = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tt", truth_table, 4'h0);
        check("rst_code", gate_code, 3'd7);
        check("rst_unstable", unstable, 0);
        check("rst_stim", {stim_a, stim_b}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        // and gate: full stimulus sequence and latency
        model = 4'h8;
        pulse_start();
        check("and_busy_start", busy, 1);
        stim_errs = 0;
        lat = 0;
        while (!done && lat < 200) begin
            if (lat < 24 && {stim_a, stim_b} != 2'((lat / 3) % 4)) stim_errs++;
            @(negedge clk);
            lat++;
        end
        check("and_stim_seq", stim_errs, 0);
        check("and_latency", lat, 25);
        check("and_busy_done", busy, 0);
        check("and_tt", truth_table, 4'h8);
        check("and_code", gate_code, 3'd0);
        check("and_unstable", unstable, 0);
        @(negedge clk);
        check("and_done_one_cycle", done, 0);
        check("and_stim_idle", {stim_a, stim_b}, 2'b00);
        check("and_hold_tt", truth_table, 4'h8);

        for (int i = 0; i < 10; i++) begin
            model = vecs[i].model;
            pulse_start();
            wait_done(lat);
            check({vecs[i].name, "_latency"}, lat, 25);
            check({vecs[i].name, "_tt"}, truth_table, vecs[i].exp_tt);
            check({vecs[i].name, "_code"}, gate_code, vecs[i].exp_code);
            check({vecs[i].name, "_unstable"}, unstable, 0);
            @(negedge clk);
        end

        // xor that inverts on vector 11 in the second pass only
        model = 4'h6;
        pulse_start();
        repeat (19) @(negedge clk);
        flip = 1'b1;
        wait_done(lat);
        flip = 1'b0;
        check("glitch_seen", (lat != 999), 1);
        check("glitch_tt", truth_table, 4'h6);
        check("glitch_unstable", unstable, 1);
        check("glitch_code", gate_code, 3'd7);
        @(negedge clk);

        // fast instance: one pass, one settle cycle, dut_y tied low
        @(negedge clk) start_f = 1'b1;
        @(negedge clk) start_f = 1'b0;
        lat = 0;
        while (!done_f && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("fast_latency", lat, 9);
        check("fast_tt", truth_table_f, 4'h0);
        check("fast_code", gate_code_f, 3'd7);
        check("fast_unstable", unstable_f, 0);
        check("fast_busy", busy_f, 0);

        // start held high for 40 cycles
        model = 4'hE;
        done_cnt = 0; first_idx = -1; second_idx = -1; busy_after = 1'b0;
        @(negedge clk) start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (first_idx < 0) first_idx = i;
                else if (second_idx < 0) second_idx = i;
            end
            if (i == 26) busy_after = busy;
            if (i == 40) start = 1'b0;
        end
        check("held_done_count", done_cnt, 2);
        check("held_first_done", first_idx, 25);
        check("held_second_done", second_idx, 51);
        check("held_rerun_busy", busy_after, 1);
        check("held_code", gate_code, 3'd1);

        // mid-run reset after a glitch run so outputs are non-reset values
        model = 4'h6;
        pulse_start();
        repeat (19) @(negedge clk);
        flip = 1'b1;
        wait_done(lat);
        flip = 1'b0;
        @(negedge clk);
        check("pre_rst_unstable", unstable, 1);
        model = 4'h8;
        pulse_start();
        repeat (19) @(negedge clk);
        check("pre_rst_stim_v2", {stim_a, stim_b}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_stim", {stim_a, stim_b}, 2'b00);
        check("async_rst_tt", truth_table, 4'h0);
        check("async_rst_code", gate_code, 3'd7);
        check("async_rst_unstable", unstable, 0);
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (done) done_cnt++;
        end
        check("rst_no_done", done_cnt, 0);
        pulse_start();
        wait_done(lat);
        check("post_rst_latency", lat, 25);
        check("post_rst_code", gate_code, 3'd0);
        check("post_rst_tt", truth_table, 4'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_identifier.md
Name: gate_identifier

Overview:
Sequential characterizer for the two-input gate library (and, or, nand, nor, xor, xnor, not). It drives an exhaustive stimulus sweep into one gate instance and captures the gate's response. It then decodes the captured truth table back into a gate-type code, performing the reverse of the gate modules. It is used as a built-in self-check beside gate instances and as a bench helper.

Parameters:
SETTLE_CYCLES, 2, cycles each stimulus vector is held before sampling; legal range 1..15
PASSES, 2, number of full 4-vector sweeps per run; legal range 1..4; passes after the first check stability

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  run request; sampled only in IDLE
dut_y  input  1  output of the gate under test
stim_a  output  1  gate input a (for not: the only input)
stim_b  output  1  gate input b
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when results update
truth_table  output  4  captured response; bit index = {a,b}
gate_code  output  3  0 and, 1 or, 2 nand, 3 nor, 4 xor, 5 xnor, 6 not, 7 unknown
unstable  output  1  a later pass disagreed with pass 0

Behaviour:
- Reset (async, rst_n low): FSM enters IDLE. stim_a, stim_b, busy, done and unstable all go to 0. truth_table=4'h0, gate_code=3'd7. Internal counters clear. Reset mid-run aborts immediately with no done pulse.
- States: IDLE, DRIVE, SAMPLE, DECODE.
- IDLE: if start=1 at a clock edge, the FSM goes to DRIVE, vector index v=0, pass p=0, settle counter 0 and busy=1. Run-local capture and mismatch registers clear. Published outputs are untouched until DECODE.
- start while busy is ignored and is not queued.
- Vector order v=0..3: {stim_a,stim_b} = 00, 01, 10, 11, i.e. {a,b}=v. The stimulus is registered and stable for the whole vector window.
- DRIVE: lasts exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE: lasts one cycle. At its closing edge dut_y is captured:
  - p=0: cap[v] <= dut_y.
  - p>0: if dut_y != cap[v], mism <= 1 (sticky for the run).
- After SAMPLE: if v<3, v++ and go to DRIVE. Else if p<PASSES-1, p++, v=0 and go to DRIVE. Else go to DECODE.
- DECODE: lasts one cycle. At its closing edge:
  - truth_table<=cap and unstable<=mism.
  - gate_code is decoded from cap: 8 and, E or, 7 nand, 1 nor, 6 xor, 9 xnor, 3 not, any other value 7.
  - gate_code is forced to 7 if mism=1.
  - done=1 for exactly the next cycle, busy=0, and the FSM returns to IDLE.
- After DECODE, stim_a/stim_b return to 0.
- Latency: start accepted at edge E0 -> done high during the cycle after edge E0 + PASSES*4*(SETTLE_CYCLES+1) + 1. Defaults give E0+25.
- Back-to-back runs: start may be high in the same cycle as done. The FSM is in IDLE then, so the start is accepted.
- Outputs hold their last results until the next DECODE or reset.
- Constant gates (0 or F) and a buffer pattern (C) decode to 7 with unstable=0.

Test Plan:
- and model on dut_y, start pulse, defaults -> stim sequence 00,01,10,11 twice with each vector held 3 cycles; done at E0+25; truth_table=4'h8, gate_code=0, unstable=0, busy low the same cycle.
- Sweep each of or/nand/nor/xor/xnor/not -> truth_table E/7/1/6/9/3 and gate_code 1/2/3/4/5/6 respectively.
- xor model whose output inverts on vector 11 in pass 1 only -> truth_table=4'h6, unstable=1, gate_code=7.
- dut_y tied 0 with SETTLE_CYCLES=1, PASSES=1 -> done at E0+9, truth_table=4'h0, gate_code=7, unstable=0.
- start held high for 40 cycles -> a second run starts the cycle done is high; no extra runs start while busy.
- rst_n pulsed low mid-run (pass 1, v=2) -> outputs return to reset values asynchronously, no done pulse; a new start then completes normally.
